ps2_cmd_decoder: RTL

//  Upstream stage of the game-play engine. Turns PS/2 set-2 scan-code bytes from the keyboard receiver into one-cycle cmd[15:0] pulses.

---
 rtl/ps2_cmd_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ps2_cmd_decoder.sv
// PS/2 set-2 scan-code to game command decoder with prefix tracking and Shift state.
// Optional macro PS2_CMD_ARROWS_EN maps extended arrow/nav keys onto moves.
module ps2_cmd_decoder #(
  parameter int TIMEOUT_W      = 21,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  scan_data,
  input  logic        scan_stb,
  output logic [15:0] cmd,
  output logic        shift
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [2:0]           skip;
  logic                 left_held, right_held;
  logic                 left_nxt, right_nxt;
  logic [15:0]          dec;

  function automatic logic [15:0] plain_map(input logic [7:0] b);
    case (b)
      8'h4B, 8'h74: plain_map = 16'h0080; // E
      8'h31, 8'h7A: plain_map = 16'h0040; // SE
      8'h3B, 8'h72: plain_map = 16'h0020; // S
      8'h32, 8'h69: plain_map = 16'h0010; // SW
      8'h33, 8'h6B: plain_map = 16'h0008; // W
      8'h35, 8'h6C: plain_map = 16'h0004; // NW
      8'h42, 8'h75: plain_map = 16'h0002; // N
      8'h3C, 8'h7D: plain_map = 16'h0001; // NE
      8'h05:        plain_map = 16'h0100;
      8'h06:        plain_map = 16'h0200;
      8'h04:        plain_map = 16'h0400;
      8'h15:        plain_map = 16'h0800;
      8'h49, 8'h73: plain_map = 16'h1000;
      8'h1D:        plain_map = 16'h2000;
      8'h2C:        plain_map = 16'h4000;
      default:      plain_map = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ext_map(input logic [7:0] b);
`ifdef PS2_CMD_ARROWS_EN
    case (b)
      8'h74:   ext_map = 16'h0080;
      8'h7A:   ext_map = 16'h0040;
      8'h72:   ext_map = 16'h0020;
      8'h69:   ext_map = 16'h0010;
      8'h6B:   ext_map = 16'h0008;
      8'h6C:   ext_map = 16'h0004;
      8'h75:   ext_map = 16'h0002;
      8'h7D:   ext_map = 16'h0001;
      default: ext_map = 16'h0000;
    endcase
`else
    ext_map = (b == 8'h00) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  always_comb begin
    left_nxt  = left_held;
    right_nxt = right_held;
    dec       = 16'h0000;
    if (scan_stb) begin
      case (state)
        IDLE: begin
          if (scan_data == 8'h12)      left_nxt = 1'b1;
          else if (scan_data == 8'h59) right_nxt = 1'b1;
          else if (scan_data == 8'hAA) begin
            left_nxt  = 1'b0;
            right_nxt = 1'b0;
          end else if (scan_data != 8'hE0 && scan_data != 8'hF0 && scan_data != 8'hE1)
            dec = plain_map(scan_data);
        end
        EXT:     if (scan_data != 8'hF0) dec = ext_map(scan_data);
        BRK: begin
          if (scan_data == 8'h12) left_nxt  = 1'b0;
          if (scan_data == 8'h59) right_nxt = 1'b0;
        end
        default: ;
      endcase
    end
    // Repeat flag only qualifies moves, using the Shift state before this byte.
    if (dec[7:0] != 8'h00 && (left_held || right_held)) dec[15] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      skip       <= '0;
      left_held  <= 1'b0;
      right_held <= 1'b0;
      cmd        <= '0;
      shift      <= 1'b0;
    end else begin
      cmd        <= dec;
      left_held  <= left_nxt;
      right_held <= right_nxt;
      shift      <= left_nxt | right_nxt;
      if (scan_stb) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (scan_data == 8'hE0)      state <= EXT;
            else if (scan_data == 8'hF0) state <= BRK;
            else if (scan_data == 8'hE1) begin
              state <= SKIP;
              skip  <= 3'd7;
            end
          end
          EXT:    state <= (scan_data == 8'hF0) ? EXTBRK : IDLE;
          SKIP: begin
            skip <= skip - 3'd1;
            if (skip == 3'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A strobe arriving on the expiry cycle takes the branch above instead.
        if (tcnt == TMAX) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule
